mem_dump_unit: RTL and testbench
================================

# mem_dump_unit

Synthesizable data-memory dump engine for the RISC-V core. It watches the fetched instruction word and, on a trigger match or an explicit start pulse, walks the data memory from index 0 to DEPTH-1. Each word goes out as an (address, data) record on a valid/ready stream. It sits beside the data memory's second read port in `Main` and replaces the bench-only dump loop, so memory contents can be captured on hardware through a UART or trace sink.

## Interface
Parameters:
- `DATA_W`, 32: data-memory word width.
- `DEPTH`, 1024: number of words dumped, at indices 0..DEPTH-1.
- `ADDR_W`, 10: index width; must satisfy 2^ADDR_W >= DEPTH.
- `TRIGGER_INST`, 32'h00000793: instruction word that starts a dump.

Ports:
- `clock` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `inst_f` in 32: instruction currently fetched by the core.
- `start` in 1: manual start pulse, honoured only in IDLE.
- `mem_addr` out ADDR_W: word index to the data-memory read port.
- `mem_rdata` in DATA_W: read data, valid exactly one cycle after `mem_addr`.
- `dump_valid` out 1: a stream record is present.
- `dump_ready` in 1: the sink accepts the record.
- `dump_addr` out 32: byte address of the record, equal to index*4.
- `dump_data` out DATA_W: word value.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a dump completes.

## Operation
- Trigger is a rising edge of the match `inst_f == TRIGGER_INST`, using a registered copy `match_d` that resets to 0. If `inst_f` already matches when reset releases, that counts as an edge.
- A held or repeating match produces one dump only; the unit re-arms after `inst_f` differs for at least 1 cycle.
- `go = trigger_edge | start`. `go` is ignored outside IDLE.
- FSM states:
  - IDLE: on `go`, set idx=0 and go to READ.
  - READ: drive `mem_addr`=idx; go to LATCH.
  - LATCH: capture `mem_rdata` into `dump_data`, capture idx*4 into `dump_addr`, set `dump_valid`=1; go to SEND.
  - SEND: hold the record. On `dump_valid & dump_ready`, clear `dump_valid`. If idx==DEPTH-1 go to DONE; otherwise idx+1 and go to READ.
  - DONE: `done`=1 for this cycle; go to IDLE.
- `dump_addr` is idx zero-extended to 32 bits, then shifted left by 2. The last address is (DEPTH-1)*4, e.g. 0xFFC for DEPTH=1024. idx never wraps.
- Stream rules:
  - While `dump_valid` is high and `dump_ready` is low, `dump_addr` and `dump_data` stay stable.
  - `dump_valid` never drops without a handshake.
  - `dump_ready` has no effect when `dump_valid` is low.
- `mem_addr` holds its last value outside READ. It is 0 after reset.

## Timing
- Reset values: state IDLE, idx 0, `mem_addr` 0, `dump_valid` 0, `dump_addr` 0, `dump_data` 0, `busy` 0, `done` 0, `match_d` 0.
- A `go` sampled at edge T gives READ and `busy`=1 from T, and `dump_valid`=1 from T+2 for index 0.
- With `dump_ready` held high, throughput is 1 word per 3 cycles. Total time from `go` to the `done` pulse is 3*DEPTH+1 cycles.
- A `go` that coincides with the DONE cycle is ignored. The next `go` is accepted in IDLE, one cycle later at the earliest.
- Reset asserted mid-dump clears all state immediately (asynchronously). No partial record or `done` is emitted. After release the unit is in IDLE and re-arms per the edge rule.

## Configuration
- `MEM_DUMP_SKIP_ZERO_EN`:
  - Defined: in LATCH, a word equal to 0 is not emitted. The FSM goes straight to READ with idx+1, or to DONE if idx==DEPTH-1, spending 2 cycles on that word. `done` still pulses exactly once per dump, even if every word is zero.
  - Undefined: all DEPTH words are emitted, as described above.

## Test plan
- DEPTH=8, memory holds word i = 0x100+i, `dump_ready`=1, `inst_f` set to 0x00000793 for 1 cycle -> 8 records (0x0,0x100) … (0x1C,0x107); `done` pulses 25 cycles after `go`.
- `inst_f` held at 0x00000793 for 100 cycles -> exactly one dump. Drop `inst_f` to 0x00000013 for 1 cycle, then back to 0x00000793 -> a second dump.
- Backpressure: `dump_ready` toggles 0,0,1 repeatedly -> no record lost or duplicated; `dump_addr` and `dump_data` are stable while stalled.
- `start` pulses at index 3 of a dump, and again in the DONE cycle -> both are ignored; exactly 8 records and one `done`.
- Reset asserted while in SEND at index 5 -> all outputs go to 0 within the same cycle. A new `start` then dumps from 0x0.
- With `MEM_DUMP_SKIP_ZERO_EN` defined and only indices 2 and 6 nonzero -> records (0x8, v2) and (0x18, v6) only, then one `done`.

Source files
------------

// File: rtl/mem_dump_unit.sv
// Data-memory dump engine: on an instruction trigger edge or start pulse, streams
// every word as an (index*4, data) record. Define MEM_DUMP_SKIP_ZERO_EN to drop zero words.
module mem_dump_unit #(
  parameter int          DATA_W       = 32,
  parameter int          DEPTH        = 1024,
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] TRIGGER_INST = 32'h00000793
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       inst_f,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_SEND, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q, mem_addr_q;
  logic                match_q, dump_valid_q, busy_q, done_q;
  logic [31:0]         dump_addr_q;
  logic [DATA_W-1:0]   dump_data_q;

  logic                match, go, last, skip_word;
  logic [ADDR_W-1:0]   idx_inc;
  logic [31:0]         rec_addr;

  // match_q resets to 0, so a trigger already present at reset release is an edge
  assign match    = (inst_f == TRIGGER_INST);
  assign go       = (match & ~match_q) | start;
  assign last     = (idx_q == LAST_IDX);
  assign idx_inc  = idx_q + ADDR_W'(1);
  assign rec_addr = 32'({idx_q, 2'b00});

`ifdef MEM_DUMP_SKIP_ZERO_EN
  assign skip_word = (mem_rdata == '0);
`else
  assign skip_word = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      mem_addr_q   <= '0;
      match_q      <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      match_q <= match;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (go) begin
          idx_q      <= '0;
          mem_addr_q <= '0;
          busy_q     <= 1'b1;
          state_q    <= S_READ;
        end
        S_READ: state_q <= S_LATCH;
        S_LATCH: begin
          if (skip_word) begin
            if (last) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q      <= idx_inc;
              mem_addr_q <= idx_inc;
              state_q    <= S_READ;
            end
          end else begin
            dump_data_q  <= mem_rdata;
            dump_addr_q  <= rec_addr;
            dump_valid_q <= 1'b1;
            state_q      <= S_SEND;
          end
        end
        S_SEND: if (dump_ready) begin
          dump_valid_q <= 1'b0;
          if (last) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q      <= idx_inc;
            mem_addr_q <= idx_inc;
            state_q    <= S_READ;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit (DEPTH=8) with a scoreboard of expected records.
module tb_mem_dump_unit;
`ifdef MEM_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
  localparam int STOP = 6;
`else
  localparam bit SKIP = 1'b0;
  localparam int STOP = 5;
`endif
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset, start, dump_ready, dump_valid, busy, done;
  logic [31:0] inst_f, dump_addr, dump_data, mem_rdata;
  logic [2:0]  mem_addr;
  logic [31:0] mem [DEPTH];

  logic [63:0] q[$];
  int          checks = 0, errors = 0;
  int          rec_cnt = 0, done_cnt = 0;
  int          rdy_mode = 0, bp_cnt = 0;
  int          r0, d0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pa, pd;

  mem_dump_unit #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(3), .TRIGGER_INST(32'h00000793)) dut (
    .clock(clock), .reset(reset), .inst_f(inst_f), .start(start),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_rdata <= mem[mem_addr];

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0: dump_ready = 1'b1;
      1: begin
        dump_ready = (bp_cnt == 2);
        bp_cnt = (bp_cnt == 2) ? 0 : bp_cnt + 1;
      end
      default: dump_ready = (32'(mem_addr) != STOP);
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [63:0] e;
    if (reset) pv = 1'b0;
    else begin
      if (pv && !pr) begin
        chk("stall_valid", 64'(dump_valid), 64'd1);
        chk("stall_addr", 64'(dump_addr), 64'(pa));
        chk("stall_data", 64'(dump_data), 64'(pd));
      end
      if (dump_valid && dump_ready) begin
        chk("rec_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rec", {dump_addr, dump_data}, e);
        end
        rec_cnt++;
      end
      if (done) done_cnt++;
      pv = dump_valid; pr = dump_ready; pa = dump_addr; pd = dump_data;
    end
  end

  function automatic bit emitted(input int i);
    return !(SKIP && mem[i] == 32'd0);
  endfunction

  function automatic int exp_lat();
    int s = 1;
    for (int i = 0; i < DEPTH; i++) s += emitted(i) ? 3 : 2;
    return s;
  endfunction

  function automatic int exp_recs(input int upto);
    int s = 0;
    for (int i = 0; i < upto; i++) if (emitted(i)) s++;
    return s;
  endfunction

  task automatic push_dump();
    for (int i = 0; i < DEPTH; i++)
      if (emitted(i)) q.push_back({32'(i * 4), mem[i]});
  endtask

  task automatic wait_done(input string tag, input int n0, input int lat, input bit chk_lat);
    int n = n0;
    while (done !== 1'b1 && n < 400) begin
      @(posedge clock); #1; n++;
    end
    chk(tag, 64'(done), 64'd1);
    if (chk_lat) chk({tag, "_lat"}, 64'(n), 64'(lat));
  endtask

  task automatic end_checks(input string tag, input int rs, input int ds);
    chk({tag, "_recs"}, 64'(rec_cnt - rs), 64'(exp_recs(DEPTH)));
    chk({tag, "_dones"}, 64'(done_cnt - ds), 64'd1);
    chk({tag, "_qempty"}, 64'(q.size()), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++)
      mem[i] = (!SKIP || i == 2 || i == 6) ? 32'h100 + 32'(i) : 32'd0;
    reset = 1'b1; start = 1'b0; inst_f = 32'h00000013; dump_ready = 1'b0;
    #12;
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_valid", 64'(dump_valid), 64'd0);
    chk("rst_addr", 64'(dump_addr), 64'd0);
    chk("rst_data", 64'(dump_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;

    // single-cycle trigger
    inst_f = 32'h00000793; r0 = rec_cnt; d0 = done_cnt; push_dump();
    @(posedge clock); #1 inst_f = 32'h00000013;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clock); #1;
    chk("t1_latch_valid", 64'(dump_valid), 64'd0);
    @(posedge clock); #1;
    chk("t1_first_valid", 64'(dump_valid), 64'(emitted(0)));
    chk("t1_first_addr", 64'(dump_addr), 64'd0);
    wait_done("t1_done", 3, exp_lat(), 1'b1);
    @(posedge clock); #1;
    end_checks("t1", r0, d0);

    // held trigger gives one dump; re-arm after one non-matching cycle
    inst_f = 32'h00000793; r0 = rec_cnt; d0 = done_cnt; push_dump();
    repeat (100) @(posedge clock);
    #1 end_checks("t2a", r0, d0);
    inst_f = 32'h00000013;
    @(posedge clock); #1;
    inst_f = 32'h00000793; r0 = rec_cnt; d0 = done_cnt; push_dump();
    wait_done("t2b_done", 0, exp_lat(), 1'b1);
    inst_f = 32'h00000013;
    @(posedge clock); #1;
    end_checks("t2b", r0, d0);

    // backpressure 0,0,1
    rdy_mode = 1; bp_cnt = 0;
    start = 1'b1; r0 = rec_cnt; d0 = done_cnt; push_dump();
    @(posedge clock); #1 start = 1'b0;
    wait_done("t3_done", 0, 0, 1'b0);
    @(posedge clock); #1;
    end_checks("t3", r0, d0);
    rdy_mode = 0;
    @(posedge clock); #1;

    // start mid-dump and in the DONE cycle are ignored
    start = 1'b1; r0 = rec_cnt; d0 = done_cnt; push_dump();
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    while (mem_addr !== 3'd3 && n < 100) begin @(posedge clock); #1; n++; end
    chk("t4_reach_idx3", 64'(mem_addr), 64'd3);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done("t4_done", 0, 0, 1'b0);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    chk("t4_after_done_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    end_checks("t4", r0, d0);

    // async reset while stalled in SEND
    rdy_mode = 2;
    start = 1'b1; r0 = rec_cnt; d0 = done_cnt; push_dump();
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    while (!(dump_valid === 1'b1 && dump_addr === 32'(STOP * 4)) && n < 100) begin
      @(posedge clock); #1; n++;
    end
    chk("t5_stall_addr", 64'(dump_addr), 64'(STOP * 4));
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("t5_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("t5_rst_valid", 64'(dump_valid), 64'd0);
    chk("t5_rst_addr", 64'(dump_addr), 64'd0);
    chk("t5_rst_data", 64'(dump_data), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_partial_recs", 64'(rec_cnt - r0), 64'(exp_recs(STOP)));
    q.delete();
    @(posedge clock); #1 reset = 1'b0; rdy_mode = 0;
    @(posedge clock); #1;
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    start = 1'b1; r0 = rec_cnt; d0 = done_cnt; push_dump();
    @(posedge clock); #1 start = 1'b0;
    chk("t5_restart_addr", 64'(mem_addr), 64'd0);
    wait_done("t5_done", 1, exp_lat(), 1'b1);
    @(posedge clock); #1;
    end_checks("t5", r0, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
